exe_v2: RTL and testbench

- Execute stage of the 5-stage Thumb pipeline (IF/ID/EX/MEM/WB).
- Selects each operand from its decoded value or one of three forwarded results, performs the Thumb ALU/shift operation, and holds the NZCV flags.
- Result, destination tag and flags are registered, so the block also forms the EX/MEM boundary.

---
 rtl/exe_v2_if.sv | 31 +++
 rtl/exe_v2.sv | 204 ++++++++++++++++++++
 tb/tb_exe_v2.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/exe_v2_if.sv
// Operand, forwarding and result bundle between the decode side and the EX/MEM boundary.
interface exe_v2_if;
  logic [31:0] X;
  logic [31:0] Y;
  logic [3:0]  RD_IN;
  logic [7:0]  SHAMT;
  logic [4:0]  OPTYPE;
  logic        XY_SEL;
  logic        VALIDRD_IN;
  logic [31:0] EXE_DF1;
  logic [31:0] EXE_DF2;
  logic [31:0] MEM_DF;
  logic [3:0]  HZ_CTRLX;
  logic [3:0]  HZ_CTRLY;
  logic [31:0] Z_RESULT;
  logic [3:0]  RD_OUT;
  logic        VALIDRD_OUT;
  logic [3:0]  NZCVUPDATE;

  modport master (
    output X, Y, RD_IN, SHAMT, OPTYPE, XY_SEL, VALIDRD_IN,
    output EXE_DF1, EXE_DF2, MEM_DF, HZ_CTRLX, HZ_CTRLY,
    input  Z_RESULT, RD_OUT, VALIDRD_OUT, NZCVUPDATE
  );

  modport slave (
    input  X, Y, RD_IN, SHAMT, OPTYPE, XY_SEL, VALIDRD_IN,
    input  EXE_DF1, EXE_DF2, MEM_DF, HZ_CTRLX, HZ_CTRLY,
    output Z_RESULT, RD_OUT, VALIDRD_OUT, NZCVUPDATE
  );
endinterface

// File: rtl/exe_v2.sv
// Thumb execute stage: operand forwarding, ALU/shifter, NZCV flags; outputs form the EX/MEM
// pipeline register.
module exe_v2 (
  input logic     CLK,
  input logic     RST,
  exe_v2_if.slave bus
);

  localparam logic [4:0] OpAnd   = 5'd0;
  localparam logic [4:0] OpEor   = 5'd1;
  localparam logic [4:0] OpLsl   = 5'd2;
  localparam logic [4:0] OpLsr   = 5'd3;
  localparam logic [4:0] OpAsr   = 5'd4;
  localparam logic [4:0] OpAdc   = 5'd5;
  localparam logic [4:0] OpSbc   = 5'd6;
  localparam logic [4:0] OpRor   = 5'd7;
  localparam logic [4:0] OpTst   = 5'd8;
  localparam logic [4:0] OpNeg   = 5'd9;
  localparam logic [4:0] OpCmp   = 5'd10;
  localparam logic [4:0] OpCmn   = 5'd11;
  localparam logic [4:0] OpOrr   = 5'd12;
  localparam logic [4:0] OpMul   = 5'd13;
  localparam logic [4:0] OpBic   = 5'd14;
  localparam logic [4:0] OpMvn   = 5'd15;
  localparam logic [4:0] OpAdd   = 5'd16;
  localparam logic [4:0] OpSub   = 5'd17;
  localparam logic [4:0] OpMov   = 5'd18;
  localparam logic [4:0] OpAddnf = 5'd19;
  localparam logic [4:0] OpPassa = 5'd20;

  logic [31:0] z_q, z_d;
  logic [3:0]  rd_q;
  logic        valid_q, valid_d;
  logic        n_q, z_flag_q, c_q, v_q;
  logic [3:0]  nzcv_d;

  logic [31:0] op_a, op_b;
  logic [7:0]  sh;
  logic [4:0]  amt;
  logic        sh_big;
  logic [31:0] sh_res;
  logic        sh_c;
  logic [32:0] lsl_ext, lsr_ext, asr_ext;
  logic [63:0] ror_ext;
  logic [31:0] add_a, add_b;
  logic        add_cin;
  logic [32:0] sum;
  logic        add_v;
  logic [31:0] mul_res;

  // Lowest set select bit wins; bit3 alone or no bits falls back to the decoded operand.
  function automatic logic [31:0] fwd_sel(input logic [3:0] ctrl, input logic [31:0] dec,
                                          input logic [31:0] df1, input logic [31:0] df2,
                                          input logic [31:0] mem);
    if (ctrl[0])      return df1;
    else if (ctrl[1]) return df2;
    else if (ctrl[2]) return mem;
    else              return dec;
  endfunction

  always_comb begin
    op_a = fwd_sel(bus.HZ_CTRLX, bus.X, bus.EXE_DF1, bus.EXE_DF2, bus.MEM_DF);
    op_b = fwd_sel(bus.HZ_CTRLY, bus.Y, bus.EXE_DF1, bus.EXE_DF2, bus.MEM_DF);
    sh   = bus.XY_SEL ? op_b[7:0] : bus.SHAMT;
  end

  assign amt     = sh[4:0];
  assign sh_big  = |sh[7:5];
  assign mul_res = op_a * op_b;

  // Each extended shift carries the last bit shifted out in its extra position.
  always_comb begin
    lsl_ext = {1'b0, op_a} << amt;
    lsr_ext = {op_a, 1'b0} >> amt;
    asr_ext = $signed({op_a, 1'b0}) >>> amt;
    ror_ext = {op_a, op_a} >> amt;
    sh_res  = op_a;
    sh_c    = c_q;
    if (sh != 8'd0) begin
      case (bus.OPTYPE)
        OpLsl: begin
          if (!sh_big) begin
            sh_res = lsl_ext[31:0];
            sh_c   = lsl_ext[32];
          end else begin
            sh_res = '0;
            sh_c   = (sh == 8'd32) ? op_a[0] : 1'b0;
          end
        end
        OpLsr: begin
          if (!sh_big) begin
            sh_res = lsr_ext[32:1];
            sh_c   = lsr_ext[0];
          end else begin
            sh_res = '0;
            sh_c   = (sh == 8'd32) ? op_a[31] : 1'b0;
          end
        end
        OpAsr: begin
          if (!sh_big) begin
            sh_res = asr_ext[32:1];
            sh_c   = asr_ext[0];
          end else begin
            sh_res = {32{op_a[31]}};
            sh_c   = op_a[31];
          end
        end
        OpRor: begin
          sh_res = ror_ext[31:0];
          sh_c   = ror_ext[31];
        end
        default: ;
      endcase
    end
  end

  // Subtraction is A + ~B + cin, so carry-out already means "no borrow".
  always_comb begin
    add_a   = op_a;
    add_b   = op_b;
    add_cin = 1'b0;
    case (bus.OPTYPE)
      OpAdc: add_cin = c_q;
      OpSbc: begin
        add_b   = ~op_b;
        add_cin = c_q;
      end
      OpNeg: begin
        add_a   = '0;
        add_b   = ~op_b;
        add_cin = 1'b1;
      end
      OpCmp, OpSub: begin
        add_b   = ~op_b;
        add_cin = 1'b1;
      end
      default: ;
    endcase
    sum   = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};
    add_v = (add_a[31] == add_b[31]) && (sum[31] != add_a[31]);
  end

  always_comb begin
    logic set_nz;
    logic c_d, v_d;
    z_d     = '0;
    valid_d = bus.VALIDRD_IN;
    set_nz  = 1'b1;
    c_d     = c_q;
    v_d     = v_q;
    case (bus.OPTYPE)
      OpAnd, OpTst: z_d = op_a & op_b;
      OpEor:        z_d = op_a ^ op_b;
      OpOrr:        z_d = op_a | op_b;
      OpMul:        z_d = mul_res;
      OpBic:        z_d = op_a & ~op_b;
      OpMvn:        z_d = ~op_b;
      OpMov:        z_d = op_b;
      OpLsl, OpLsr, OpAsr, OpRor: begin
        z_d = sh_res;
        c_d = sh_c;
      end
      OpAdc, OpSbc, OpNeg, OpCmp, OpCmn, OpAdd, OpSub: begin
        z_d = sum[31:0];
        c_d = sum[32];
        v_d = add_v;
      end
      OpAddnf: begin
        z_d    = sum[31:0];
        set_nz = 1'b0;
      end
      OpPassa: begin
        z_d    = op_a;
        set_nz = 1'b0;
      end
      default: begin
        valid_d = 1'b0;
        set_nz  = 1'b0;
      end
    endcase
    if (bus.OPTYPE == OpTst || bus.OPTYPE == OpCmp || bus.OPTYPE == OpCmn) valid_d = 1'b0;
    nzcv_d = {set_nz ? z_d[31] : n_q, set_nz ? (z_d == 32'd0) : z_flag_q, c_d, v_d};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      z_q                        <= '0;
      rd_q                       <= '0;
      valid_q                    <= 1'b0;
      {n_q, z_flag_q, c_q, v_q}  <= '0;
    end else begin
      z_q                        <= z_d;
      rd_q                       <= bus.RD_IN;
      valid_q                    <= valid_d;
      {n_q, z_flag_q, c_q, v_q}  <= nzcv_d;
    end
  end

  assign bus.Z_RESULT    = z_q;
  assign bus.RD_OUT      = rd_q;
  assign bus.VALIDRD_OUT = valid_q;
  assign bus.NZCVUPDATE  = {n_q, z_flag_q, c_q, v_q};

endmodule

// File: tb/tb_exe_v2.sv
// Directed and randomized bench for exe_v2 against an arithmetic reference model.
module tb_exe_v2;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [3:0]  mflags = 4'b0000;
  logic [31:0] df1 = 0, df2 = 0, mdf = 0;

  exe_v2_if bus ();

  exe_v2 u_dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pick(input logic [3:0] ctrl, input logic [31:0] dec);
    if (ctrl[0]) return df1;
    if (ctrl[1]) return df2;
    if (ctrl[2]) return mdf;
    return dec;
  endfunction

  function automatic logic ovf(input longint sr);
    return (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
  endfunction

  function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                input int s, input logic [3:0] fi, input logic vin,
                                output logic [31:0] res, output logic [3:0] fo, output logic vo);
    logic n, z, c, v;
    logic [63:0] t;
    longint ua, ub, sa, sb, bw;
    int r;
    {n, z, c, v} = fi;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    vo = vin;
    res = 0;
    case (op)
      0, 8: res = a & b;
      1:    res = a ^ b;
      12:   res = a | b;
      13:   res = a * b;
      14:   res = a & ~b;
      15:   res = ~b;
      18:   res = b;
      20:   res = a;
      19:   res = a + b;
      11, 16: begin
        res = a + b; c = (ua + ub) > 64'sd4294967295; v = ovf(sa + sb);
      end
      5: begin
        bw = c ? 1 : 0;
        res = a + b + {31'd0, c}; c = (ua + ub + bw) > 64'sd4294967295; v = ovf(sa + sb + bw);
      end
      10, 17: begin
        res = a - b; c = (ua >= ub); v = ovf(sa - sb);
      end
      6: begin
        bw = c ? 0 : 1;
        res = a - b - {31'd0, !c}; c = (ua >= ub + bw); v = ovf(sa - sb - bw);
      end
      9: begin
        res = 32'd0 - b; c = (b == 0); v = ovf(-sb);
      end
      2: begin
        if (s == 0) res = a;
        else if (s <= 32) begin t = {32'd0, a} << s; res = t[31:0]; c = t[32]; end
        else begin res = 0; c = 0; end
      end
      3: begin
        if (s == 0) res = a;
        else if (s <= 32) begin t = {32'd0, a} >> s; res = t[31:0]; c = a[s-1]; end
        else begin res = 0; c = 0; end
      end
      4: begin
        if (s == 0) res = a;
        else if (s < 32) begin res = $signed(a) >>> s; c = a[s-1]; end
        else begin res = a[31] ? 32'hFFFF_FFFF : 32'd0; c = a[31]; end
      end
      7: begin
        r = s % 32;
        if (s == 0) res = a;
        else if (r == 0) begin res = a; c = a[31]; end
        else begin res = (a >> r) | (a << (32 - r)); c = res[31]; end
      end
      default: vo = 1'b0;
    endcase
    if (op == 8 || op == 10 || op == 11) vo = 1'b0;
    if (op <= 18) begin n = res[31]; z = (res == 0); end
    fo = {n, z, c, v};
  endfunction

  task automatic do_op(input string tag, input logic [4:0] op, input logic [31:0] x,
                       input logic [31:0] y, input logic [3:0] rd, input logic [7:0] shamt,
                       input logic xysel, input logic vin, input logic [3:0] hx,
                       input logic [3:0] hy);
    logic [31:0] a, b, er;
    logic [3:0]  ef;
    logic        ev;
    @(negedge CLK);
    bus.X = x; bus.Y = y; bus.RD_IN = rd; bus.SHAMT = shamt; bus.OPTYPE = op;
    bus.XY_SEL = xysel; bus.VALIDRD_IN = vin; bus.HZ_CTRLX = hx; bus.HZ_CTRLY = hy;
    bus.EXE_DF1 = df1; bus.EXE_DF2 = df2; bus.MEM_DF = mdf;
    a = pick(hx, x);
    b = pick(hy, y);
    model(op, a, b, int'(xysel ? b[7:0] : shamt), mflags, vin, er, ef, ev);
    @(posedge CLK);
    #1;
    check({tag, ".z"}, bus.Z_RESULT, er);
    check({tag, ".rd"}, {28'd0, bus.RD_OUT}, {28'd0, rd});
    check({tag, ".valid"}, {31'd0, bus.VALIDRD_OUT}, {31'd0, ev});
    check({tag, ".nzcv"}, {28'd0, bus.NZCVUPDATE}, {28'd0, ef});
    mflags = ef;
  endtask

  function automatic logic [31:0] rword();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  task automatic check_zero_outputs(input string tag);
    check({tag, ".z"}, bus.Z_RESULT, 32'd0);
    check({tag, ".rd"}, {28'd0, bus.RD_OUT}, 32'd0);
    check({tag, ".valid"}, {31'd0, bus.VALIDRD_OUT}, 32'd0);
    check({tag, ".nzcv"}, {28'd0, bus.NZCVUPDATE}, 32'd0);
  endtask

  initial begin
    logic [7:0] shtab [8];
    shtab = '{8'd0, 8'd1, 8'd31, 8'd32, 8'd33, 8'd64, 8'd255, 8'd16};
    bus.X = 0; bus.Y = 0; bus.RD_IN = 0; bus.SHAMT = 0; bus.OPTYPE = 0; bus.XY_SEL = 0;
    bus.VALIDRD_IN = 0; bus.HZ_CTRLX = 0; bus.HZ_CTRLY = 0;
    bus.EXE_DF1 = 0; bus.EXE_DF2 = 0; bus.MEM_DF = 0;
    repeat (2) @(posedge CLK);
    #1;
    check_zero_outputs("reset0");
    @(negedge CLK);
    RST = 1'b0;

    do_op("pre", 5'd16, 32'h1234_5678, 32'h8765_4321, 4'd9, 0, 0, 1, 0, 0);
    @(negedge CLK);
    #2;
    RST = 1'b1;
    #1;
    check_zero_outputs("async_rst");
    mflags = 4'b0000;
    @(negedge CLK);
    RST = 1'b0;

    do_op("add34", 5'd16, 3, 4, 4'd2, 0, 0, 1, 0, 0);
    check("add34.z_c", bus.Z_RESULT, 32'd7);
    check("add34.nzcv_c", {28'd0, bus.NZCVUPDATE}, 32'b0000);
    do_op("addovf", 5'd16, 32'h7FFF_FFFF, 1, 4'd1, 0, 0, 1, 0, 0);
    check("addovf.c", {bus.Z_RESULT[31:28], bus.NZCVUPDATE}, {4'h8, 4'b1001});
    do_op("sub55", 5'd17, 5, 5, 4'd1, 0, 0, 1, 0, 0);
    check("sub55.c", {28'd0, bus.NZCVUPDATE}, 32'b0110);
    do_op("cmp35", 5'd10, 3, 5, 4'd3, 0, 0, 1, 0, 0);
    check("cmp35.c", {27'd0, bus.VALIDRD_OUT, bus.NZCVUPDATE}, 32'b01000);
    do_op("addnf", 5'd19, 1, 1, 4'd4, 0, 0, 1, 0, 0);
    check("addnf.c", {bus.Z_RESULT[3:0], bus.NZCVUPDATE}, {4'd2, 4'b1000});
    do_op("addwrap", 5'd16, 32'hFFFF_FFFF, 1, 4'd5, 0, 0, 1, 0, 0);
    check("addwrap.c", {28'd0, bus.NZCVUPDATE}, 32'b0110);
    do_op("adc", 5'd5, 1, 1, 4'd6, 0, 0, 1, 0, 0);
    check("adc.c", bus.Z_RESULT, 32'd3);

    do_op("lsl1", 5'd2, 32'h8000_0001, 0, 4'd7, 8'd1, 0, 1, 0, 0);
    check("lsl1.c", {bus.Z_RESULT, bus.NZCVUPDATE[1]}, {32'd2, 1'b1});
    do_op("lsr32", 5'd3, 32'h8000_0001, 32, 4'd7, 8'd0, 1, 1, 0, 0);
    check("lsr32.c", {bus.Z_RESULT, bus.NZCVUPDATE[1]}, {32'd0, 1'b1});
    do_op("asr4", 5'd4, 32'h8000_0001, 0, 4'd7, 8'd4, 0, 1, 0, 0);
    check("asr4.c", {bus.Z_RESULT, bus.NZCVUPDATE[1]}, {32'hF800_0000, 1'b0});
    do_op("ror1", 5'd7, 32'h8000_0001, 0, 4'd7, 8'd1, 0, 1, 0, 0);
    check("ror1.c", {bus.Z_RESULT, bus.NZCVUPDATE[1]}, {32'hC000_0000, 1'b1});

    df1 = 10; df2 = 20; mdf = 30;
    do_op("fwd1", 5'd16, 1, 0, 4'd8, 0, 0, 1, 4'b0001, 0);
    check("fwd1.c", bus.Z_RESULT, 32'd10);
    do_op("fwd2", 5'd16, 1, 0, 4'd8, 0, 0, 1, 4'b0010, 0);
    check("fwd2.c", bus.Z_RESULT, 32'd20);
    do_op("fwd3", 5'd16, 1, 0, 4'd8, 0, 0, 1, 4'b0100, 0);
    check("fwd3.c", bus.Z_RESULT, 32'd30);
    do_op("fwdpri", 5'd16, 1, 0, 4'd8, 0, 0, 1, 4'b0011, 0);
    check("fwdpri.c", bus.Z_RESULT, 32'd10);
    do_op("fwddec", 5'd16, 1, 0, 4'd8, 0, 0, 1, 4'b1000, 0);
    check("fwddec.c", bus.Z_RESULT, 32'd1);
    do_op("fwdy", 5'd18, 0, 5, 4'd8, 0, 0, 1, 0, 4'b0110);
    check("fwdy.c", bus.Z_RESULT, 32'd20);

    do_op("preovf", 5'd16, 32'h7FFF_FFFF, 1, 4'd1, 0, 0, 1, 0, 0);
    do_op("mul", 5'd13, 32'h1_0000, 32'h1_0000, 4'd2, 0, 0, 1, 0, 0);
    check("mul.c", {bus.Z_RESULT, bus.NZCVUPDATE}, {32'd0, 4'b0101});
    do_op("op25", 5'd25, 7, 9, 4'd3, 0, 0, 1, 0, 0);
    check("op25.c", {bus.Z_RESULT, 3'd0, bus.VALIDRD_OUT, bus.NZCVUPDATE}, {32'd0, 4'd0, 4'b0101});

    for (int i = 0; i < 300; i++) begin
      df1 = rword(); df2 = rword(); mdf = rword();
      do_op("rand", 5'($urandom_range(0, 31)), rword(), rword(), 4'($urandom),
            shtab[$urandom_range(0, 7)], 1'($urandom), 1'($urandom),
            ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'd0,
            ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
